tc_serial_decode: RTL and testbench
===================================

TC_SERIAL_DECODE -- requirements
Module: tc_serial_decode

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal values are 2 to 32.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to convert; sampled only in IDLE.
REQ-005 a  input  WIDTH  two's-complement operand; captured on an accepted start.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when the result is valid.
REQ-008 sign  output  1  sign of the captured operand (1 = negative).
REQ-009 mag  output  WIDTH  unsigned magnitude of the captured operand.
REQ-010 min_neg  output  1  high when the operand equals the most negative value (1 followed by zeros).
REQ-011 err  output  1  high when the captured operand contained X or Z (see Configuration).

Function
REQ-012 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a into a shift register, latch sign=a[WIDTH-1], clear the bit counter and the "seen-one" flag, and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-015 In SHIFT, the block SHALL process exactly one bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-016 Per-bit rule when sign=1: output bit = input bit while seen-one=0; set seen-one after the first 1; output bit = inverted input bit after that.
REQ-017 Per-bit rule when sign=0: output bit = input bit.
REQ-018 Output bits SHALL shift MSB-in into the result register, so the LSB lands at mag[0] after WIDTH shifts.
REQ-019 After the WIDTH-th SHIFT cycle, the block SHALL enter DONE. DONE lasts one cycle, asserts done=1, updates mag and min_neg, and then returns to IDLE.
REQ-020 Latency: start accepted at edge N -> done=1 during the cycle after edge N+WIDTH+1; the latency is fixed and does not depend on the data.
REQ-021 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the result and no queueing.
REQ-023 start asserted in the same cycle as done SHALL be ignored; start is accepted from the next IDLE cycle.
REQ-024 mag, sign, min_neg and err SHALL hold their values from done until the next done.
REQ-025 For the most negative value, mag SHALL be 2^(WIDTH-1) and min_neg=1; mag is unsigned and WIDTH bits, so no overflow occurs.
REQ-026 For zero, the result SHALL be sign=0, mag=0, min_neg=0.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during a conversion.

Reset
REQ-028 rst_n=0 SHALL force the state to IDLE, and busy, done, sign, mag, min_neg and err to 0, immediately and regardless of clk.
REQ-029 A reset in the middle of a conversion SHALL abort it with no done pulse; the first start after rst_n rises is accepted normally.

Configuration
REQ-030 Macro TC_XCHECK_EN, when defined: an accepted start with any X or Z bit in a SHALL set err=1 at the following done, with mag=0 and sign=0. This is a simulation-only check, and latency is unchanged.
REQ-031 When TC_XCHECK_EN is undefined, err SHALL be tied to 0 and X/Z propagates through the datapath unchecked.

Verification
REQ-032 The bench SHALL cover these directed scenarios (WIDTH=8):
- start with a=8'b00001010 -> done 9 cycles after accept; sign=0, mag=8'b00001010, min_neg=0.
- start with a=8'b11110110 -> sign=1, mag=8'b00001010, min_neg=0.
- a=8'b00000000 -> sign=0, mag=0; then a=8'b10000000 -> sign=1, mag=8'b10000000, min_neg=1.
- start with a=8'b11111111, then start with a=8'b00000001 three cycles later -> single done; sign=1, mag=8'b00000001; the second start is ignored.
- start with a=8'b11110110, drop rst_n 4 cycles later -> busy=0 and mag=0 at once, no done; after release, a=8'b00000011 -> mag=8'b00000011.
- With TC_XCHECK_EN defined: a=8'b1010x010 -> err=1, mag=0; then a=8'b10z01010 -> err=1. Without the macro: err=0 throughout.

Source files
------------

// File: rtl/tc_serial_decode_if.sv
// tc_serial_decode_if -- request/result bundle for tc_serial_decode.
//   start   : request to convert (sampled only when the block is idle)
//   a       : two's-complement operand, captured on an accepted start
//   busy    : conversion in progress
//   done    : one-cycle result-valid pulse
//   sign    : sign of the captured operand
//   mag     : unsigned magnitude of the captured operand
//   min_neg : operand was the most negative value
//   err     : operand contained X/Z (only when TC_XCHECK_EN is defined)
// Modports: master drives start/a, slave (the decoder) drives the results.
interface tc_serial_decode_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic             min_neg;
    logic             err;

    modport master (
        output start, a,
        input  busy, done, sign, mag, min_neg, err
    );

    modport slave (
        input  start, a,
        output busy, done, sign, mag, min_neg, err
    );
endinterface

// File: rtl/tc_serial_decode.sv
// tc_serial_decode -- bit-serial two's-complement to sign/magnitude decoder.
//
// A captured operand is walked LSB first, one bit per cycle. For negative
// operands the magnitude is formed with the serial "copy up to and including
// the first 1, then invert" rule. Results are registered when the DONE state
// is left, so done/mag/sign/min_neg/err appear together in the first idle
// cycle after DONE and then hold until the next done.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tc_serial_decode_if.slave (start/a in; busy/done/sign/mag/
//           min_neg/err out)
//
// Optional feature: define TC_XCHECK_EN to flag operands containing X/Z
// (simulation-only); otherwise err is tied low.
module tc_serial_decode #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    tc_serial_decode_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] res;
    logic             sign_q;
    logic             seen;
    logic             obit;
    logic             accept;

    logic             done_q;
    logic             sign_o;
    logic [WIDTH-1:0] mag_q;
    logic             min_neg_q;
    logic             err_q;
    logic             xflag;

    // A start coinciding with the done pulse is dropped: done is only
    // visible in an IDLE cycle, so it has to gate acceptance explicitly.
    assign accept = (state == IDLE) && bus.start && !done_q;

    // Serial negation: invert every bit above the first 1 of a negative value.
    assign obit = sr[0] ^ (sign_q & seen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sr        <= '0;
            res       <= '0;
            sign_q    <= 1'b0;
            seen      <= 1'b0;
            xflag     <= 1'b0;
            done_q    <= 1'b0;
            sign_o    <= 1'b0;
            mag_q     <= '0;
            min_neg_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr     <= bus.a;
                        sign_q <= bus.a[WIDTH-1];
                        cnt    <= '0;
                        seen   <= 1'b0;
`ifdef TC_XCHECK_EN
                        xflag  <= $isunknown(bus.a);
`else
                        xflag  <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // Output bits enter at the MSB; after WIDTH shifts the
                    // first processed bit sits at res[0].
                    res  <= {obit, res[WIDTH-1:1]};
                    sr   <= sr >> 1;
                    seen <= seen | sr[0];
                    cnt  <= cnt + CW'(1);
                end
                DONE: begin
                    if (xflag) begin
                        mag_q     <= '0;
                        sign_o    <= 1'b0;
                        min_neg_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        mag_q     <= res;
                        sign_o    <= sign_q;
                        min_neg_q <= sign_q && (res == {1'b1, {(WIDTH-1){1'b0}}});
                        err_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.sign    = sign_o;
    assign bus.mag     = mag_q;
    assign bus.min_neg = min_neg_q;
`ifdef TC_XCHECK_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_tc_serial_decode.sv
// Testbench for tc_serial_decode (WIDTH=8): table-driven directed vectors,
// hand-written multi-cycle sequences and randomized operands checked against
// an arithmetic reference model.
module tb_tc_serial_decode;
    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic clk;
    logic rst_n;

    tc_serial_decode_if #(.WIDTH(W)) bus ();

    tc_serial_decode #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    typedef struct {
        logic [W-1:0] a;
        logic         sign;
        logic [W-1:0] mag;
        logic         min_neg;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference: sign/magnitude straight from the two's-complement value.
    function automatic logic [W+1:0] model(input logic [W-1:0] v);
        logic         s;
        logic [W-1:0] m;
        s = v[W-1];
        m = s ? (~v + 1'b1) : v;
        return {s, m, (v == {1'b1, {(W-1){1'b0}}})};
    endfunction

    // Issue one conversion; returns cycles from the accepting edge to the
    // first sample with done=1 (capped at 20 on timeout).
    task automatic convert(input logic [W-1:0] v, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b1;
        bus.a     = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] v, input int lat);
        logic [W+1:0] e;
        e = model(v);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_sign"},    32'(bus.sign), 32'(e[W+1]));
        check({tag, "_mag"},     32'(bus.mag), 32'(e[W:1]));
        check({tag, "_min_neg"}, 32'(bus.min_neg), 32'(e[0]));
        check({tag, "_err"},     32'(bus.err), 32'd0);
    endtask

    initial begin
        int           lat;
        int           ndone;
        logic [W-1:0] v;
        logic [W-1:0] held;

        n_total = 0;
        n_pass  = 0;
        vecs[0] = '{8'b00001010, 1'b0, 8'b00001010, 1'b0};
        vecs[1] = '{8'b11110110, 1'b1, 8'b00001010, 1'b0};
        vecs[2] = '{8'b00000000, 1'b0, 8'b00000000, 1'b0};
        vecs[3] = '{8'b10000000, 1'b1, 8'b10000000, 1'b1};
        vecs[4] = '{8'b01111111, 1'b0, 8'b01111111, 1'b0};
        vecs[5] = '{8'b11111111, 1'b1, 8'b00000001, 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        rst_n     = 1'b0;
        #23;
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_done",    32'(bus.done), 32'd0);
        check("rst_sign",    32'(bus.sign), 32'd0);
        check("rst_mag",     32'(bus.mag), 32'd0);
        check("rst_min_neg", 32'(bus.min_neg), 32'd0);
        check("rst_err",     32'(bus.err), 32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].a, lat);
            check("tbl_latency", 32'(lat), 32'(LAT));
            check("tbl_sign",    32'(bus.sign), 32'(vecs[i].sign));
            check("tbl_mag",     32'(bus.mag), 32'(vecs[i].mag));
            check("tbl_min_neg", 32'(bus.min_neg), 32'(vecs[i].min_neg));
            check("tbl_err",     32'(bus.err), 32'd0);
        end

        // Results hold after the done pulse
        held = bus.mag;
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 32'(bus.done), 32'd0);
        check("hold_mag",  32'(bus.mag), 32'(held));
        check("hold_sign", 32'(bus.sign), 32'd1);

        // Start during busy is ignored: exactly one done, result of 0xFF
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'b11111111;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'b00000001;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                check("busy_ign_sign", 32'(bus.sign), 32'd1);
                check("busy_ign_mag",  32'(bus.mag), 32'd1);
            end
        end
        check("busy_ign_ndone", 32'(ndone), 32'd1);

        // Start coinciding with done is ignored
        convert(8'b00000101, lat);
        check_result("pre_same", 8'b00000101, lat);
        bus.start = 1'b1;
        bus.a     = 8'b11000000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("same_cycle_busy", 32'(bus.busy), 32'd0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("same_cycle_ndone", 32'(ndone), 32'd0);
        check("same_cycle_mag",   32'(bus.mag), 32'd5);

        // Reset mid-conversion aborts with no done
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'b11110110;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_mag",  32'(bus.mag), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort_ndone", 32'(ndone), 32'd0);
        convert(8'b00000011, lat);
        check_result("after_rst", 8'b00000011, lat);

`ifdef TC_XCHECK_EN
        convert(8'b1010x010, lat);
        check("x_latency", 32'(lat), 32'(LAT));
        check("x_err",     32'(bus.err), 32'd1);
        check("x_mag",     32'(bus.mag), 32'd0);
        check("x_sign",    32'(bus.sign), 32'd0);
        convert(8'b10z01010, lat);
        check("z_err",     32'(bus.err), 32'd1);
        check("z_mag",     32'(bus.mag), 32'd0);
        convert(8'b10001010, lat);
        check_result("x_clear", 8'b10001010, lat);
`endif

        // Randomized operands against the model
        for (int i = 0; i < 40; i++) begin
            v = W'($urandom);
            convert(v, lat);
            check_result("rand", v, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
